// File: rtl/datapath_pkg.sv
// Shared datapath constants and elaboration-time helpers for the pipelined
// operand/forwarding select logic.
package datapath_pkg;

  localparam int DATAPATH_WIDTH = 32;

  // Ceiling log2 with a floor of 1 bit, so a select port always has a width.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register holding {valid, data}.
// Priority per edge: reset, then flush (bubble), then stall (hold), then load.
module pipe_stage
  import datapath_pkg::*;
#(
  parameter int WIDTH = DATAPATH_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH:0]   d,
  output logic [WIDTH:0]   q
);

  logic [WIDTH:0] data_q;
  logic [WIDTH:0] data_d;

  always_comb begin
    data_d = d;
    if (flush) begin
      data_d = '0;
    end else if (stall) begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/muxn_pipe.sv
// N-input select mux registered through a DEPTH-stage valid pipeline, with a
// sticky flag for accepted samples whose select is out of range.
module muxn_pipe
  import datapath_pkg::*;
#(
  parameter int WIDTH  = DATAPATH_WIDTH,
  parameter int NUM_IN = 4,
  parameter int DEPTH  = 1,
  localparam int SEL_W = clog2(NUM_IN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    sel_err
);

  localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);

  logic [WIDTH-1:0]            mux_value;
  logic                        accept;
  logic                        sel_err_q;
  logic                        sel_err_d;
  logic [DEPTH-1:0][WIDTH:0]   stage_q;

  // Out-of-range selects and bubbles both produce zero data.
  always_comb begin
    mux_value = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) mux_value = in_data[k*WIDTH +: WIDTH];
    end
    if (!in_valid) mux_value = '0;
  end

  assign accept = in_valid & ~stall & ~flush;

  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && ({1'b0, sel} >= NUM_IN_EXT)) sel_err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
          .clock (clock),
          .reset (reset),
          .stall (stall),
          .flush (flush),
          .d     ({in_valid, mux_value}),
          .q     (stage_q[gi])
        );
      end else begin : g_tail
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
          .clock (clock),
          .reset (reset),
          .stall (stall),
          .flush (flush),
          .d     (stage_q[gi-1]),
          .q     (stage_q[gi])
        );
      end
    end
  endgenerate

  assign out_data  = stage_q[DEPTH-1][WIDTH-1:0];
  assign out_valid = stage_q[DEPTH-1][WIDTH];
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_muxn_pipe.sv
// Bench for muxn_pipe: a 4x32 depth-2 instance and a 3x8 depth-1 instance
// share control inputs and are checked against a stage-array reference model.
module tb_muxn_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, in_valid, stall, flush;
  logic [1:0]  sel;
  logic [31:0] word_a [4];
  logic [7:0]  word_b [3];
  logic [127:0] in_data_a;
  logic [23:0]  in_data_b;

  logic [31:0] out_data_a;
  logic        out_valid_a, sel_err_a;
  logic [7:0]  out_data_b;
  logic        out_valid_b, sel_err_b;

  always_comb begin
    in_data_a = '0;
    in_data_b = '0;
    for (int k = 0; k < 4; k++) in_data_a[k*32 +: 32] = word_a[k];
    for (int k = 0; k < 3; k++) in_data_b[k*8 +: 8] = word_b[k];
  end

  muxn_pipe #(.WIDTH(32), .NUM_IN(4), .DEPTH(2)) dut_a (
    .clock(clock), .reset(reset), .in_data(in_data_a), .sel(sel),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_data(out_data_a), .out_valid(out_valid_a), .sel_err(sel_err_a)
  );

  muxn_pipe #(.WIDTH(8), .NUM_IN(3), .DEPTH(1)) dut_b (
    .clock(clock), .reset(reset), .in_data(in_data_b), .sel(sel),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_data(out_data_b), .out_valid(out_valid_b), .sel_err(sel_err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each stage is {valid, data}; index 0 is nearest the input.
  logic [32:0] ea [2];
  logic [8:0]  eb;
  logic        erra, errb;

  task automatic model_step();
    logic [31:0] ma;
    logic [7:0]  mb;
    ma = (in_valid && sel < 4) ? word_a[sel] : 32'h0;
    mb = (in_valid && sel < 3) ? word_b[sel] : 8'h0;
    if (reset) begin
      ea[0] = '0; ea[1] = '0; eb = '0; erra = 1'b0; errb = 1'b0;
    end else if (flush) begin
      ea[0] = '0; ea[1] = '0; eb = '0;
    end else if (!stall) begin
      ea[1] = ea[0];
      ea[0] = {in_valid, ma};
      eb    = {in_valid, mb};
      if (in_valid && sel >= 3) errb = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; stall = 1'b0; flush = 1'b0; sel = 2'd1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin reset = 1'b0; in_valid = 1'b0; end
      tick();
      n_cmp++;
      if (out_valid_a !== 1'b0 || out_data_a !== 32'h0 || sel_err_a !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_a cyc%0d: got v=%b d=%h e=%b want 0/0/0", c, out_valid_a, out_data_a, sel_err_a);
      end
      n_cmp++;
      if (out_valid_b !== 1'b0 || out_data_b !== 8'h0 || sel_err_b !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_b cyc%0d: got v=%b d=%h e=%b want 0/0/0", c, out_valid_b, out_data_b, sel_err_b);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_select();
    logic [31:0] want_d;
    logic        want_v;
    for (int k = 0; k < 4; k++) word_a[k] = 32'h11111111 * k;
    for (int t = 1; t <= 7; t++) begin
      in_valid = (t <= 4);
      sel = 2'(t - 1);
      tick();
      want_v = (t >= 2 && t <= 5);
      want_d = want_v ? 32'h11111111 * (t - 2) : 32'h0;
      n_cmp++;
      if (out_valid_a !== want_v || out_data_a !== want_d) begin
        n_bad++;
        $display("FAIL select t%0d: got v=%b d=%h want v=%b d=%h", t, out_valid_a, out_data_a, want_v, want_d);
      end
    end
    $display("test_select done");
  endtask

  task automatic test_stall();
    logic [31:0] frozen_d;
    logic        frozen_v;
    for (int t = 0; t < 12; t++) begin
      in_valid = 1'b1;
      sel = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) word_a[k] = $urandom;
      stall = (t >= 4 && t <= 6);
      if (t == 4) begin frozen_d = out_data_a; frozen_v = out_valid_a; end
      tick();
      n_cmp++;
      if (out_valid_a !== ea[1][32] || out_data_a !== ea[1][31:0]) begin
        n_bad++;
        $display("FAIL stall_model t%0d: got v=%b d=%h want v=%b d=%h", t, out_valid_a, out_data_a, ea[1][32], ea[1][31:0]);
      end
      if (stall) begin
        n_cmp++;
        if (out_valid_a !== frozen_v || out_data_a !== frozen_d) begin
          n_bad++;
          $display("FAIL stall_hold t%0d: got v=%b d=%h want v=%b d=%h", t, out_valid_a, out_data_a, frozen_v, frozen_d);
        end
      end
    end
    stall = 1'b0;
    $display("test_stall done");
  endtask

  task automatic test_flush_stall();
    in_valid = 1'b1;
    for (int t = 0; t < 2; t++) begin
      sel = 2'($urandom_range(0, 3));
      tick();
    end
    flush = 1'b1; stall = 1'b1;
    for (int t = 0; t < 2; t++) begin
      tick();
      flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if (out_valid_a !== 1'b0 || out_data_a !== 32'h0) begin
        n_bad++;
        $display("FAIL flush_stall t%0d: got v=%b d=%h want v=0 d=0", t, out_valid_a, out_data_a);
      end
    end
    $display("test_flush_stall done");
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < 3; k++) word_b[k] = 8'($urandom_range(1, 255));
    in_valid = 1'b1; sel = 2'd3;
    tick();
    n_cmp++;
    if (out_data_b !== 8'h00 || out_valid_b !== 1'b1 || sel_err_b !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_sample: got v=%b d=%h e=%b want v=1 d=00 e=1", out_valid_b, out_data_b, sel_err_b);
    end
    n_cmp++;
    if (sel_err_a !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_pow2: got e=%b want 0", sel_err_a);
    end
    flush = 1'b1; sel = 2'd0;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (sel_err_b !== 1'b1 || out_valid_b !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_flush: got e=%b v=%b want e=1 v=0", sel_err_b, out_valid_b);
    end
    $display("test_out_of_range done");
  endtask

  task automatic test_bubble();
    logic ea_before, eb_before;
    ea_before = sel_err_a; eb_before = errb;
    in_valid = 1'b0; sel = 2'd1;
    word_a[1] = 32'h000000AB; word_b[1] = 8'hAB;
    tick(); tick();
    n_cmp++;
    if (out_valid_a !== 1'b0 || out_data_a !== 32'h0 || sel_err_a !== ea_before) begin
      n_bad++;
      $display("FAIL bubble_a: got v=%b d=%h e=%b want v=0 d=0 e=%b", out_valid_a, out_data_a, sel_err_a, ea_before);
    end
    n_cmp++;
    if (out_valid_b !== 1'b0 || out_data_b !== 8'h0 || sel_err_b !== eb_before) begin
      n_bad++;
      $display("FAIL bubble_b: got v=%b d=%h e=%b want v=0 d=0 e=%b", out_valid_b, out_data_b, sel_err_b, eb_before);
    end
    $display("test_bubble done");
  endtask

  task automatic test_err_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (sel_err_b !== 1'b0) begin
      n_bad++;
      $display("FAIL err_reset: got e=%b want 0", sel_err_b);
    end
    $display("test_err_reset done");
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      reset    = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 8);
      stall    = ($urandom_range(0, 99) < 15);
      in_valid = ($urandom_range(0, 99) < 70);
      sel      = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) word_a[k] = $urandom;
      for (int k = 0; k < 3; k++) word_b[k] = 8'($urandom);
      tick();
      n_cmp++;
      if (out_valid_a !== ea[1][32] || out_data_a !== ea[1][31:0] || sel_err_a !== erra) begin
        n_bad++;
        $display("FAIL random_a t%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b", t,
                 out_valid_a, out_data_a, sel_err_a, ea[1][32], ea[1][31:0], erra);
      end
      n_cmp++;
      if (out_valid_b !== eb[8] || out_data_b !== eb[7:0] || sel_err_b !== errb) begin
        n_bad++;
        $display("FAIL random_b t%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b", t,
                 out_valid_b, out_data_b, sel_err_b, eb[8], eb[7:0], errb);
      end
    end
    reset = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; sel = 2'd0;
    for (int k = 0; k < 4; k++) word_a[k] = 32'h0;
    for (int k = 0; k < 3; k++) word_b[k] = 8'h0;
    ea[0] = '0; ea[1] = '0; eb = '0; erra = 1'b0; errb = 1'b0;
    test_reset();
    test_select();
    test_stall();
    test_flush_stall();
    test_out_of_range();
    test_bubble();
    test_err_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
